// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage register.
// The entry struct below is the default-width layout; the block declares its own sized copy.
package pipe_pkg;

    localparam int EXCCODE_W = 5;
    localparam int DEF_PC_W = 32;
    localparam int DEF_DATA_W = 128;
    localparam logic [31:0] DEF_EXC_PC = 32'h0000_4180;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_DATA_W-1:0] data;
        logic [EXCCODE_W-1:0]  exccode;
        logic                  bd;
    } pipe_entry_t;

endpackage

// File: rtl/pipe_slot.sv
// Single pipeline entry register: load a beat, clear to zero, or clear to a given pc.
// Clear-to-pc wins over clear, which wins over load.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int DATA_W = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic                 i_clear,
    input  logic                 i_clear_pc,
    input  logic [PC_W-1:0]      i_clr_pc,
    input  logic [PC_W-1:0]      i_pc,
    input  logic [DATA_W-1:0]    i_data,
    input  logic [EXCCODE_W-1:0] i_exccode,
    input  logic                 i_bd,
    output logic [PC_W-1:0]      o_pc,
    output logic [DATA_W-1:0]    o_data,
    output logic [EXCCODE_W-1:0] o_exccode,
    output logic                 o_bd
);

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [DATA_W-1:0]    data;
        logic [EXCCODE_W-1:0] exccode;
        logic                 bd;
    } slot_t;

    slot_t r_entry;
    slot_t w_in;

    assign w_in = '{pc: i_pc, data: i_data, exccode: i_exccode, bd: i_bd};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_entry <= '0;
        end else if (i_clear_pc) begin
            r_entry    <= '0;
            r_entry.pc <= i_clr_pc;
        end else if (i_clear) begin
            r_entry <= '0;
        end else if (i_load) begin
            r_entry <= w_in;
        end
    end

    assign o_pc      = r_entry.pc;
    assign o_data    = r_entry.data;
    assign o_exccode = r_entry.exccode;
    assign o_bd      = r_entry.bd;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage register with optional 2-entry skid buffer,
// flush (bubble with pc 0) and exception request (bubble with the handler pc).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | no beat held; out_valid low, main fields keep last contents
// ST_ONE   | main entry holds the output beat
// ST_TWO   | main and skid both full; input stalled (SKID=1 only)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              DATA_W = 128,
    parameter int              PC_W   = 32,
    parameter logic [PC_W-1:0] EXC_PC = PC_W'(DEF_EXC_PC),
    parameter bit              SKID   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 req,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [EXCCODE_W-1:0] in_exccode,
    input  logic                 in_bd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [DATA_W-1:0]    out_data,
    output logic [EXCCODE_W-1:0] out_exccode,
    output logic                 out_bd,
    output logic [1:0]           occupancy
);

    pipe_state_e r_state;
    logic        r_in_ready;
    logic [1:0]  r_occupancy;

    logic                 w_clear;
    logic                 w_out_valid;
    logic                 w_in_ready;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_main_load;
    logic                 w_main_from_skid;
    logic                 w_skid_load;
    logic [PC_W-1:0]      w_clr_pc;
    logic [PC_W-1:0]      w_main_pc;
    logic [DATA_W-1:0]    w_main_data;
    logic [EXCCODE_W-1:0] w_main_exccode;
    logic                 w_main_bd;
    logic [PC_W-1:0]      w_skid_pc;
    logic [DATA_W-1:0]    w_skid_data;
    logic [EXCCODE_W-1:0] w_skid_exccode;
    logic                 w_skid_bd;

    // req and flush share the bubble path; req only changes the pc stamped into it.
    assign w_clear  = req | flush;
    assign w_clr_pc = req ? EXC_PC : '0;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_ready  = SKID ? r_in_ready : (!w_out_valid || out_ready);
    assign w_in_fire   = in_valid && w_in_ready && !w_clear;
    assign w_out_fire  = w_out_valid && out_ready && !w_clear;

    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_occupancy <= 2'd0;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_state     <= ST_ONE;
                        r_occupancy <= 2'd1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && !w_out_fire && SKID) begin
                        r_state     <= ST_TWO;
                        r_in_ready  <= 1'b0;
                        r_occupancy <= 2'd2;
                    end else if (!w_in_fire && w_out_fire) begin
                        r_state     <= ST_EMPTY;
                        r_occupancy <= 2'd0;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        r_state     <= ST_ONE;
                        r_in_ready  <= 1'b1;
                        r_occupancy <= 2'd1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_occupancy <= 2'd0;
                end
            endcase
        end
    end

    // Slot load enables mirror the transitions above; ONE with an input-only beat spills into skid.
    always_comb begin
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        unique case (r_state)
            ST_EMPTY: w_main_load = w_in_fire;
            ST_ONE: begin
                w_main_load = w_in_fire && (w_out_fire || !SKID);
                w_skid_load = w_in_fire && !w_out_fire && SKID;
            end
            ST_TWO: begin
                w_main_load      = w_out_fire;
                w_main_from_skid = w_out_fire;
            end
            default: ;
        endcase
    end

    assign w_main_pc      = w_main_from_skid ? w_skid_pc      : in_pc;
    assign w_main_data    = w_main_from_skid ? w_skid_data    : in_data;
    assign w_main_exccode = w_main_from_skid ? w_skid_exccode : in_exccode;
    assign w_main_bd      = w_main_from_skid ? w_skid_bd      : in_bd;

    pipe_slot #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_main_load),
        .i_clear    (1'b0),
        .i_clear_pc (w_clear),
        .i_clr_pc   (w_clr_pc),
        .i_pc       (w_main_pc),
        .i_data     (w_main_data),
        .i_exccode  (w_main_exccode),
        .i_bd       (w_main_bd),
        .o_pc       (out_pc),
        .o_data     (out_data),
        .o_exccode  (out_exccode),
        .o_bd       (out_bd)
    );

    if (SKID) begin : g_skid
        pipe_slot #(
            .PC_W   (PC_W),
            .DATA_W (DATA_W)
        ) u_skid (
            .clk        (clk),
            .reset      (reset),
            .i_load     (w_skid_load),
            .i_clear    (w_clear),
            .i_clear_pc (1'b0),
            .i_clr_pc   ('0),
            .i_pc       (in_pc),
            .i_data     (in_data),
            .i_exccode  (in_exccode),
            .i_bd       (in_bd),
            .o_pc       (w_skid_pc),
            .o_data     (w_skid_data),
            .o_exccode  (w_skid_exccode),
            .o_bd       (w_skid_bd)
        );
    end else begin : g_no_skid
        assign w_skid_pc      = '0;
        assign w_skid_data    = '0;
        assign w_skid_exccode = '0;
        assign w_skid_bd      = 1'b0;
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign occupancy = r_occupancy;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance,
// each with a scoreboard queue filled on input beats and drained on output beats.
module tb_pipe_stage_reg;

    typedef struct {
        logic [31:0]  pc;
        logic [127:0] data;
        logic [4:0]   exc;
        logic         bd;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, flush, req, in_valid, out_ready;
    logic [31:0]  in_pc;
    logic [127:0] in_data;
    logic [4:0]   in_exccode;
    logic         in_bd;
    logic         in_ready, out_valid, out_bd;
    logic [31:0]  out_pc;
    logic [127:0] out_data;
    logic [4:0]   out_exccode;
    logic [1:0]   occupancy;

    logic         z_flush, z_req, z_in_valid, z_out_ready;
    logic [31:0]  z_in_pc;
    logic [127:0] z_in_data;
    logic [4:0]   z_in_exccode;
    logic         z_in_bd;
    logic         z_in_ready, z_out_valid, z_out_bd;
    logic [31:0]  z_out_pc;
    logic [127:0] z_out_data;
    logic [4:0]   z_out_exccode;
    logic [1:0]   z_occupancy;

    pipe_stage_reg #(.SKID(1'b1)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .req(req),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
        .in_exccode(in_exccode), .in_bd(in_bd),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
        .out_exccode(out_exccode), .out_bd(out_bd), .occupancy(occupancy)
    );

    pipe_stage_reg #(.SKID(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .flush(z_flush), .req(z_req),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_pc(z_in_pc), .in_data(z_in_data),
        .in_exccode(z_in_exccode), .in_bd(z_in_bd),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_pc(z_out_pc), .out_data(z_out_data),
        .out_exccode(z_out_exccode), .out_bd(z_out_bd), .occupancy(z_occupancy)
    );

    int n_chk  = 0;
    int n_pass = 0;
    beat_t q1[$];
    beat_t q0[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [127:0] mkdata(input logic [31:0] pc);
        return {pc, ~pc, pc ^ 32'hA5A5_5A5A, 32'hC0DE_0000 | pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: pop/compare on output beats, push on input beats, flush on clear.
    always @(negedge clk) begin
        beat_t b;
        if (reset || flush || req) begin
            q1.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("sb1_nonempty", 128'(q1.size() != 0), 128'(1));
                if (q1.size() != 0) begin
                    b = q1.pop_front();
                    chk("sb1_pc", 128'(out_pc), 128'(b.pc));
                    chk("sb1_data", out_data, b.data);
                    chk("sb1_exc", 128'(out_exccode), 128'(b.exc));
                    chk("sb1_bd", 128'(out_bd), 128'(b.bd));
                end
            end
            if (in_valid && in_ready) q1.push_back('{in_pc, in_data, in_exccode, in_bd});
        end
        if (reset || z_flush || z_req) begin
            q0.delete();
        end else begin
            if (z_out_valid && z_out_ready) begin
                chk("sb0_nonempty", 128'(q0.size() != 0), 128'(1));
                if (q0.size() != 0) begin
                    b = q0.pop_front();
                    chk("sb0_pc", 128'(z_out_pc), 128'(b.pc));
                    chk("sb0_data", z_out_data, b.data);
                end
            end
            if (z_in_valid && z_in_ready) q0.push_back('{z_in_pc, z_in_data, z_in_exccode, z_in_bd});
        end
    end

    task automatic drive1(input logic [31:0] pc, input logic [4:0] exc, input logic bd);
        in_valid = 1'b1; in_pc = pc; in_data = mkdata(pc); in_exccode = exc; in_bd = bd;
    endtask

    task automatic send1(input logic [31:0] pc, input logic [4:0] exc, input logic bd);
        bit took = 1'b0;
        drive1(pc, exc, bd);
        for (int i = 0; i < 20 && !took; i++) begin
            took = in_ready;
            tick();
        end
        in_valid = 1'b0;
        chk("send1_accept", 128'(took), 128'(1));
    endtask

    task automatic send0(input logic [31:0] pc);
        bit took = 1'b0;
        z_in_valid = 1'b1; z_in_pc = pc; z_in_data = mkdata(pc);
        z_in_exccode = pc[6:2]; z_in_bd = pc[3];
        for (int i = 0; i < 20 && !took; i++) begin
            took = z_in_ready;
            tick();
        end
        z_in_valid = 1'b0;
        chk("send0_accept", 128'(took), 128'(1));
    endtask

    task automatic drain1();
        for (int i = 0; i < 20 && occupancy != 2'd0; i++) tick();
        chk("drain_occ", 128'(occupancy), 128'(0));
        chk("drain_sb", 128'(q1.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; req = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_data = '0; in_exccode = '0; in_bd = 1'b0;
        z_flush = 1'b0; z_req = 1'b0; z_in_valid = 1'b0; z_out_ready = 1'b0;
        z_in_pc = '0; z_in_data = '0; z_in_exccode = '0; z_in_bd = 1'b0;
        tick(); tick();
        reset = 1'b0;

        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_pc", 128'(out_pc), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_occ", 128'(occupancy), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst0_out_valid", 128'(z_out_valid), 128'(0));
        chk("rst0_in_ready", 128'(z_in_ready), 128'(1));

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] pc;
            pc = 32'h3000 + 32'(4 * i);
            drive1(pc, pc[6:2], pc[2]);
            tick();
            chk("stream_valid", 128'(out_valid), 128'(1));
            chk("stream_pc", 128'(out_pc), 128'(pc));
            chk("stream_occ", 128'(occupancy), 128'(1));
            chk("stream_in_ready", 128'(in_ready), 128'(1));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_empty_valid", 128'(out_valid), 128'(0));
        chk("stream_retained_pc", 128'(out_pc), 128'(32'h3008));
        chk("stream_empty_occ", 128'(occupancy), 128'(0));

        // Skid fill, upstream stall, then in-order drain
        out_ready = 1'b0;
        send1(32'h3000, 5'd1, 1'b0);
        chk("skid_occ1", 128'(occupancy), 128'(1));
        chk("skid_rdy1", 128'(in_ready), 128'(1));
        send1(32'h3004, 5'd2, 1'b1);
        chk("skid_occ2", 128'(occupancy), 128'(2));
        chk("skid_rdy2", 128'(in_ready), 128'(0));
        drive1(32'h3008, 5'd3, 1'b0);
        tick();
        chk("skid_hold_occ", 128'(occupancy), 128'(2));
        chk("skid_hold_rdy", 128'(in_ready), 128'(0));
        chk("skid_hold_pc", 128'(out_pc), 128'(32'h3000));
        out_ready = 1'b1;
        send1(32'h3008, 5'd3, 1'b0);
        drain1();

        // req in TWO with an input beat present
        out_ready = 1'b0;
        send1(32'h5000, 5'd4, 1'b0);
        send1(32'h5004, 5'd5, 1'b1);
        chk("req_pre_occ", 128'(occupancy), 128'(2));
        drive1(32'h5008, 5'd6, 1'b1);
        req = 1'b1;
        tick();
        req = 1'b0; in_valid = 1'b0;
        chk("req_valid", 128'(out_valid), 128'(0));
        chk("req_pc", 128'(out_pc), 128'(32'h4180));
        chk("req_data", out_data, 128'(0));
        chk("req_exc", 128'(out_exccode), 128'(0));
        chk("req_bd", 128'(out_bd), 128'(0));
        chk("req_occ", 128'(occupancy), 128'(0));
        chk("req_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        repeat (4) tick();
        chk("req_no_ghost", 128'(out_valid), 128'(0));

        // flush and req together: req wins
        out_ready = 1'b0;
        send1(32'h6000, 5'd7, 1'b1);
        flush = 1'b1; req = 1'b1;
        tick();
        flush = 1'b0; req = 1'b0;
        chk("both_pc", 128'(out_pc), 128'(32'h4180));
        chk("both_valid", 128'(out_valid), 128'(0));

        // flush alone with a held beat
        send1(32'h6100, 5'd8, 1'b0);
        chk("flush_pre_valid", 128'(out_valid), 128'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_pc", 128'(out_pc), 128'(0));
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_occ", 128'(occupancy), 128'(0));
        chk("flush_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        send1(32'h6200, 5'd9, 1'b1);
        drain1();

        // reset in TWO with stamped exception fields
        out_ready = 1'b0;
        send1(32'h7000, 5'd12, 1'b1);
        send1(32'h7004, 5'd12, 1'b1);
        chk("rst2_pre_occ", 128'(occupancy), 128'(2));
        drive1(32'h7008, 5'd12, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        chk("rst2_valid", 128'(out_valid), 128'(0));
        chk("rst2_pc", 128'(out_pc), 128'(0));
        chk("rst2_data", out_data, 128'(0));
        chk("rst2_exc", 128'(out_exccode), 128'(0));
        chk("rst2_bd", 128'(out_bd), 128'(0));
        chk("rst2_occ", 128'(occupancy), 128'(0));
        chk("rst2_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        repeat (4) tick();
        chk("rst2_no_stale", 128'(out_valid), 128'(0));

        // SKID=0: combinational in_ready and pass-through
        z_out_ready = 1'b0;
        send0(32'h8000);
        chk("z_held_valid", 128'(z_out_valid), 128'(1));
        chk("z_held_rdy", 128'(z_in_ready), 128'(0));
        chk("z_held_occ", 128'(z_occupancy), 128'(1));
        z_out_ready = 1'b1;
        #1;
        chk("z_comb_rdy", 128'(z_in_ready), 128'(1));
        for (int i = 1; i < 4; i++) begin
            logic [31:0] pc;
            pc = 32'h8000 + 32'(4 * i);
            z_in_valid = 1'b1; z_in_pc = pc; z_in_data = mkdata(pc);
            z_in_exccode = pc[6:2]; z_in_bd = pc[3];
            tick();
            chk("z_pass_pc", 128'(z_out_pc), 128'(pc));
            chk("z_pass_rdy", 128'(z_in_ready), 128'(1));
        end
        z_in_valid = 1'b0;
        tick();
        chk("z_end_occ", 128'(z_occupancy), 128'(0));
        chk("z_end_sb", 128'(q0.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
